// File: rtl/uplus_eth_pkg.sv
// rtl/uplus_eth_pkg.sv - shared types and helpers for the CMAC link controller
package uplus_eth_pkg;

    localparam int RETRY_W = 4;

    typedef enum logic [1:0] {G_QRST, G_QWAIT, G_RUN} g_state_t;

    typedef enum logic [2:0] {CH_IDLE, CH_RST, CH_WAIT, CH_UP, CH_FAIL} ch_state_t;

    function automatic int cnt_width(input int max_cyc);
        return (max_cyc < 1) ? 1 : $clog2(max_cyc + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uplus_eth_ch_link_fsm.sv
// rtl/uplus_eth_ch_link_fsm.sv - one channel's reset/wait/up/fail sequencer
module uplus_eth_ch_link_fsm
    import uplus_eth_pkg::*;
#(
    parameter int CH_RST_CYC   = 128,
    parameter int LINK_TMO_CYC = 1048576,
    parameter int STABLE_CYC   = 1024,
    parameter int MAX_RETRY    = 7,
    parameter int TMR_W        = 21
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_run,
    input  logic               i_lock_loss,
    input  logic               i_restart,
    input  logic               i_pg,
    input  logic               i_rx,
    output logic               o_ch_reset,
    output logic               o_link_up,
    output logic               o_link_fail,
    output logic [RETRY_W-1:0] o_retry_cnt
);

    localparam int STB_W = cnt_width(STABLE_CYC);
    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(CH_RST_CYC - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(LINK_TMO_CYC - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYC - 1);

    ch_state_t          r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [STB_W-1:0]   r_stable;
    logic [RETRY_W-1:0] r_retry;
    logic               r_ch_reset;
    logic               r_link_up;
    logic               r_link_fail;

    logic [RETRY_W-1:0] w_retry_inc;
    logic               w_force_idle;

    assign w_retry_inc  = (r_retry == '1) ? r_retry : r_retry + RETRY_W'(1);
    // Lock loss outranks a restart request; missing powergood only loses to a restart.
    assign w_force_idle = i_lock_loss || (!i_restart && !i_pg);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= CH_IDLE;
            r_timer     <= '0;
            r_stable    <= '0;
            r_retry     <= '0;
            r_ch_reset  <= 1'b1;
            r_link_up   <= 1'b0;
            r_link_fail <= 1'b0;
        end else begin
            r_timer <= (r_timer == '1) ? r_timer : r_timer + TMR_W'(1);
            if (w_force_idle) begin
                r_state     <= CH_IDLE;
                r_timer     <= '0;
                r_stable    <= '0;
                r_ch_reset  <= 1'b1;
                r_link_up   <= 1'b0;
                r_link_fail <= 1'b0;
            end else if (i_restart) begin
                r_state     <= CH_RST;
                r_timer     <= '0;
                r_stable    <= '0;
                r_retry     <= '0;
                r_ch_reset  <= 1'b1;
                r_link_up   <= 1'b0;
                r_link_fail <= 1'b0;
            end else begin
                case (r_state)
                    CH_IDLE: begin
                        if (i_run) begin
                            r_state <= CH_RST;
                            r_timer <= '0;
                        end
                    end
                    CH_RST: begin
                        if (r_timer == RST_LAST) begin
                            r_state    <= CH_WAIT;
                            r_timer    <= '0;
                            r_stable   <= '0;
                            r_ch_reset <= 1'b0;
                        end
                    end
                    CH_WAIT: begin
                        if (i_rx && r_stable == STB_LAST) begin
                            r_state   <= CH_UP;
                            r_timer   <= '0;
                            r_link_up <= 1'b1;
                        end else if (r_timer == TMO_LAST) begin
                            r_timer    <= '0;
                            r_stable   <= '0;
                            r_ch_reset <= 1'b1;
                            r_retry    <= w_retry_inc;
                            if (MAX_RETRY != 0 && w_retry_inc == RETRY_W'(MAX_RETRY)) begin
                                r_state     <= CH_FAIL;
                                r_link_fail <= 1'b1;
                            end else begin
                                r_state <= CH_RST;
                            end
                        end else begin
                            r_stable <= i_rx ? r_stable + STB_W'(1) : '0;
                        end
                    end
                    CH_UP: begin
                        r_retry <= '0;
                        if (!i_rx) begin
                            r_state    <= CH_RST;
                            r_timer    <= '0;
                            r_ch_reset <= 1'b1;
                            r_link_up  <= 1'b0;
                        end
                    end
                    CH_FAIL: begin
                        r_ch_reset <= 1'b1;
                    end
                    default: begin
                        r_state    <= CH_IDLE;
                        r_timer    <= '0;
                        r_ch_reset <= 1'b1;
                        r_link_up  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_ch_reset  = r_ch_reset;
    assign o_link_up   = r_link_up;
    assign o_link_fail = r_link_fail;
    assign o_retry_cnt = r_retry;

endmodule

// File: rtl/uplus_eth_link_ctrl.sv
// rtl/uplus_eth_link_ctrl.sv - QPLL0 and multi-channel CMAC link bring-up controller
module uplus_eth_link_ctrl
    import uplus_eth_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int QPLL_RST_CYC = 256,
    parameter int QPLL_TMO_CYC = 65536,
    parameter int CH_RST_CYC   = 128,
    parameter int LINK_TMO_CYC = 1048576,
    parameter int STABLE_CYC   = 1024,
    parameter int MAX_RETRY    = 7
) (
    input  logic                          i_init_clk,
    input  logic                          i_sys_rst_n,
    input  logic                          i_qpll0lock,
    output logic                          o_qpll0reset,
    input  logic [CHANNELS-1:0]           i_gt_powergood,
    input  logic [CHANNELS-1:0]           i_stat_rx_status,
    output logic [CHANNELS-1:0]           o_ch_reset,
    output logic [CHANNELS-1:0]           o_link_up,
    output logic [CHANNELS-1:0]           o_link_fail,
    output logic [CHANNELS*RETRY_W-1:0]   o_retry_cnt,
    input  logic [CHANNELS-1:0]           i_ch_restart
);

    localparam int MAX_CYC = max2(max2(QPLL_RST_CYC, QPLL_TMO_CYC), max2(CH_RST_CYC, LINK_TMO_CYC));
    localparam int TMR_W   = cnt_width(MAX_CYC);
    localparam logic [TMR_W-1:0] QRST_LAST = TMR_W'(QPLL_RST_CYC - 1);
    localparam logic [TMR_W-1:0] QTMO_LAST = TMR_W'(QPLL_TMO_CYC - 1);

    logic                r_lock_s1, r_lock_s2;
    logic [CHANNELS-1:0] r_pg_s1, r_pg_s2;
    logic [CHANNELS-1:0] r_rx_s1, r_rx_s2;
    g_state_t            r_g_state;
    logic [TMR_W-1:0]    r_g_timer;
    logic                r_qpll0reset;

    logic                w_run;
    logic                w_lock_loss;

    always_ff @(posedge i_init_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_lock_s1 <= 1'b0;
            r_lock_s2 <= 1'b0;
            r_pg_s1   <= '0;
            r_pg_s2   <= '0;
            r_rx_s1   <= '0;
            r_rx_s2   <= '0;
        end else begin
            r_lock_s1 <= i_qpll0lock;
            r_lock_s2 <= r_lock_s1;
            r_pg_s1   <= i_gt_powergood;
            r_pg_s2   <= r_pg_s1;
            r_rx_s1   <= i_stat_rx_status;
            r_rx_s2   <= r_rx_s1;
        end
    end

    always_ff @(posedge i_init_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_g_state    <= G_QRST;
            r_g_timer    <= '0;
            r_qpll0reset <= 1'b1;
        end else begin
            r_g_timer <= (r_g_timer == '1) ? r_g_timer : r_g_timer + TMR_W'(1);
            case (r_g_state)
                G_QRST: begin
                    if (r_g_timer == QRST_LAST) begin
                        r_g_state    <= G_QWAIT;
                        r_g_timer    <= '0;
                        r_qpll0reset <= 1'b0;
                    end
                end
                G_QWAIT: begin
                    if (r_lock_s2) begin
                        r_g_state <= G_RUN;
                        r_g_timer <= '0;
                    end else if (r_g_timer == QTMO_LAST) begin
                        r_g_state    <= G_QRST;
                        r_g_timer    <= '0;
                        r_qpll0reset <= 1'b1;
                    end
                end
                G_RUN: begin
                    if (!r_lock_s2) begin
                        r_g_state    <= G_QRST;
                        r_g_timer    <= '0;
                        r_qpll0reset <= 1'b1;
                    end
                end
                default: begin
                    r_g_state    <= G_QRST;
                    r_g_timer    <= '0;
                    r_qpll0reset <= 1'b1;
                end
            endcase
        end
    end

    // Channels see lock loss on the same edge the global FSM drops back to G_QRST.
    assign w_run       = (r_g_state == G_RUN);
    assign w_lock_loss = w_run && !r_lock_s2;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        uplus_eth_ch_link_fsm #(
            .CH_RST_CYC   (CH_RST_CYC),
            .LINK_TMO_CYC (LINK_TMO_CYC),
            .STABLE_CYC   (STABLE_CYC),
            .MAX_RETRY    (MAX_RETRY),
            .TMR_W        (TMR_W)
        ) u_fsm (
            .i_clk        (i_init_clk),
            .i_rst_n      (i_sys_rst_n),
            .i_run        (w_run),
            .i_lock_loss  (w_lock_loss),
            .i_restart    (i_ch_restart[n]),
            .i_pg         (r_pg_s2[n]),
            .i_rx         (r_rx_s2[n]),
            .o_ch_reset   (o_ch_reset[n]),
            .o_link_up    (o_link_up[n]),
            .o_link_fail  (o_link_fail[n]),
            .o_retry_cnt  (o_retry_cnt[RETRY_W*n +: RETRY_W])
        );
    end

    assign o_qpll0reset = r_qpll0reset;

endmodule

// File: tb/tb_uplus_eth_link_ctrl.sv
// tb/tb_uplus_eth_link_ctrl.sv - scoreboard bench for uplus_eth_link_ctrl
module tb_uplus_eth_link_ctrl;

    localparam int CH    = 2;
    localparam int QRST  = 4;
    localparam int QTMO  = 32;
    localparam int CRST  = 4;
    localparam int LTMO  = 64;
    localparam int STB   = 8;
    localparam int SYNC  = 2;
    localparam int NSIG  = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          lock;
    logic          qpll0reset;
    logic [CH-1:0] pg;
    logic [CH-1:0] rx;
    logic [CH-1:0] ch_reset;
    logic [CH-1:0] link_up;
    logic [CH-1:0] link_fail;
    logic [CH*4-1:0] retry_cnt;
    logic [CH-1:0] restart;

    uplus_eth_link_ctrl #(
        .CHANNELS(CH), .QPLL_RST_CYC(QRST), .QPLL_TMO_CYC(QTMO), .CH_RST_CYC(CRST),
        .LINK_TMO_CYC(LTMO), .STABLE_CYC(STB), .MAX_RETRY(3)
    ) dut (
        .i_init_clk(clk), .i_sys_rst_n(rst_n), .i_qpll0lock(lock), .o_qpll0reset(qpll0reset),
        .i_gt_powergood(pg), .i_stat_rx_status(rx), .o_ch_reset(ch_reset), .o_link_up(link_up),
        .o_link_fail(link_fail), .o_retry_cnt(retry_cnt), .i_ch_restart(restart)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int val; } ev_t;
    ev_t   exp_q[NSIG][$];
    string names[NSIG] = '{"qpll0reset", "ch_reset0", "ch_reset1", "link_up0", "link_up1",
                           "link_fail0", "link_fail1", "retry_cnt0", "retry_cnt1"};
    int    prev[NSIG];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sig_val(input int s);
        case (s)
            0:       return int'(qpll0reset);
            1, 2:    return int'(ch_reset[s-1]);
            3, 4:    return int'(link_up[s-3]);
            5, 6:    return int'(link_fail[s-5]);
            7:       return int'(retry_cnt[3:0]);
            default: return int'(retry_cnt[7:4]);
        endcase
    endfunction

    task automatic expect_ev(input int s, input int c, input int v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        exp_q[s].push_back(e);
    endtask

    // Monitor: every output change must match the next expected event for that signal.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int s = 0; s < NSIG; s++) begin
                int  cur;
                ev_t e;
                cur = sig_val(s);
                if (cur != prev[s]) begin
                    checks++;
                    if (exp_q[s].size() == 0) begin
                        errors++;
                        $display("FAIL %s changed to %0d at cycle %0d, required no change", names[s], cur, cyc);
                    end else begin
                        e = exp_q[s].pop_front();
                        if (e.cyc != cyc || e.val != cur) begin
                            errors++;
                            $display("FAIL %s got %0d at cycle %0d, required %0d at cycle %0d",
                                     names[s], cur, cyc, e.val, e.cyc);
                        end
                    end
                    prev[s] = cur;
                end
            end
        end
    end

    task automatic check_val(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_qpll0reset"}, int'(qpll0reset), 1);
        check_val({tag, "_ch_reset"},   int'(ch_reset), 3);
        check_val({tag, "_link_up"},    int'(link_up), 0);
        check_val({tag, "_link_fail"},  int'(link_fail), 0);
        check_val({tag, "_retry_cnt"},  int'(retry_cnt), 0);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic run_iter(input int it);
        int t0, tqf, tcf, lk, d0, g, c_rise, t_up0, f, r, k;
        rst_n   = 1'b0;
        lock    = 1'b0;
        rx      = '0;
        restart = '0;
        pg      = '1;
        repeat (3) @(negedge clk);
        check_reset("reset_hold");

        lk = (it == 0) ? 10 : int'($urandom_range(1, 20));
        d0 = (it == 0) ? 20 : int'($urandom_range(1, 40));
        g  = (it == 0) ? 0  : int'($urandom_range(2, 7));

        @(negedge clk);
        rst_n = 1'b1;
        t0    = cyc;
        prev  = '{1, 1, 1, 0, 0, 0, 0, 0, 0};

        // Expected timeline derived from the cycle rules: input set after edge c acts at edge c+SYNC+1.
        tqf    = t0 + QRST;
        tcf    = tqf + lk + SYNC + 1 + 1 + CRST;
        c_rise = (g == 0) ? tcf + d0 : tcf + d0 + g + 1;
        t_up0  = c_rise + SYNC + STB;
        f      = tcf + 210;
        r      = tcf + 240;
        k      = tcf + 270;

        expect_ev(0, tqf, 0);
        expect_ev(0, k + 3, 1);
        for (int i = 0; i < 2; i++) begin
            expect_ev(0, k + 3 + QRST + i * (QRST + QTMO), 0);
            expect_ev(0, k + 3 + (i + 1) * (QRST + QTMO), 1);
        end
        expect_ev(0, k + 3 + QRST + 2 * (QRST + QTMO), 0);

        expect_ev(1, tcf, 0);
        expect_ev(1, f + 3, 1);
        expect_ev(1, f + 3 + CRST, 0);
        expect_ev(1, k + 3, 1);
        expect_ev(1, k + 88, 0);

        expect_ev(2, tcf, 0);
        for (int a = 1; a <= 3; a++) begin
            expect_ev(2, tcf + a * LTMO + (a - 1) * CRST, 1);
            expect_ev(8, tcf + a * LTMO + (a - 1) * CRST, a);
            if (a < 3) expect_ev(2, tcf + a * (LTMO + CRST), 0);
        end
        expect_ev(6, tcf + 3 * LTMO + 2 * CRST, 1);
        expect_ev(6, r + 1, 0);
        expect_ev(8, r + 1, 0);
        expect_ev(2, r + 1 + CRST, 0);
        expect_ev(2, k + 3, 1);
        expect_ev(2, k + 88, 0);

        expect_ev(3, t_up0, 1);
        expect_ev(3, f + 3, 0);
        expect_ev(3, f + 3 + CRST + STB, 1);
        expect_ev(3, k + 3, 0);

        expect_ev(4, r + 1 + CRST + STB, 1);
        expect_ev(4, k + 3, 0);

        mon_en = 1'b1;
        wait_to(tqf + lk);     lock = 1'b1;
        wait_to(tcf + d0);     rx[0] = 1'b1;
        if (g != 0) begin
            wait_to(tcf + d0 + g);     rx[0] = 1'b0;
            wait_to(tcf + d0 + g + 1); rx[0] = 1'b1;
        end
        wait_to(f);            rx[0] = 1'b0;
        wait_to(f + 1);        rx[0] = 1'b1;
        wait_to(r);            restart[1] = 1'b1;
        wait_to(r + 1);        restart[1] = 1'b0; rx[1] = 1'b1;
        wait_to(k);            lock = 1'b0;
        wait_to(k + 80);       lock = 1'b1;
        wait_to(k + 92);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset("reset_mid_wait");

        for (int s = 0; s < NSIG; s++) begin
            checks++;
            if (exp_q[s].size() != 0) begin
                errors++;
                $display("FAIL %s_pending got %0d events left, required 0", names[s], exp_q[s].size());
            end
            exp_q[s].delete();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        lock    = 1'b0;
        pg      = '1;
        rx      = '0;
        restart = '0;
        for (int it = 0; it < 3; it++) run_iter(it);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
